// File: rtl/uart_echo_fifo.sv
// uart_echo_fifo: byte FIFO that echoes received UART bytes back out through the transmitter.
// Define UART_ECHO_LINE_EN to hold bytes until a CR_BYTE-terminated line (or a full FIFO) is stored.
module uart_echo_fifo #(
    parameter int ADDR_W = 9,
    parameter logic [7:0] CR_BYTE = 8'h0D
) (
    input  logic              ICE_CLK,
    input  logic              RST_N,
    input  logic              rx_dv,
    input  logic [7:0]        rx_byte,
    input  logic              tx_done,
    output logic              tx_dv,
    output logic [7:0]        tx_byte,
    output logic [ADDR_W:0]   count,
    output logic              full,
    output logic              empty,
    output logic              overflow
);
    typedef enum logic [2:0] {IDLE, FETCH, LAUNCH, WAIT_BUSY, WAIT_IDLE} state_t;
    state_t state, state_nx;
    logic [7:0] mem [0:(1<<ADDR_W)-1];
    logic [ADDR_W:0] wr_ptr, rd_ptr;
    logic wr_en, rel_ok;

    assign empty = wr_ptr == rd_ptr;
    assign full = (wr_ptr ^ rd_ptr) == {1'b1, {ADDR_W{1'b0}}};
    assign count = wr_ptr - rd_ptr;
    assign wr_en = rx_dv && !full;

    always_ff @(posedge ICE_CLK)
        if (wr_en) mem[wr_ptr[ADDR_W-1:0]] <= rx_byte;

    // tx_byte doubles as the RAM read register: loaded on the FETCH->LAUNCH edge
    always_ff @(posedge ICE_CLK or negedge RST_N)
        if (!RST_N) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            overflow <= 1'b0;
            tx_byte <= 8'h00;
        end else begin
            wr_ptr <= wr_ptr + (ADDR_W+1)'(wr_en);
            rd_ptr <= rd_ptr + (ADDR_W+1)'(tx_dv);
            overflow <= overflow || (rx_dv && full);
            if (state == FETCH) tx_byte <= mem[rd_ptr[ADDR_W-1:0]];
        end

`ifdef UART_ECHO_LINE_EN
    logic [ADDR_W:0] lines;
    always_ff @(posedge ICE_CLK or negedge RST_N)
        if (!RST_N) lines <= '0;
        else lines <= lines + (ADDR_W+1)'(wr_en && rx_byte == CR_BYTE) - (ADDR_W+1)'(tx_dv && tx_byte == CR_BYTE);
    assign rel_ok = lines != '0 || full;
`else
    assign rel_ok = !empty;
`endif

    always_ff @(posedge ICE_CLK or negedge RST_N)
        if (!RST_N) state <= IDLE;
        else state <= state_nx;

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:      state_nx = rel_ok && tx_done ? FETCH : IDLE;
            FETCH:     state_nx = LAUNCH;
            LAUNCH:    state_nx = WAIT_BUSY;
            WAIT_BUSY: state_nx = tx_done ? WAIT_BUSY : WAIT_IDLE;
            WAIT_IDLE: state_nx = tx_done ? IDLE : WAIT_IDLE;
            default:   state_nx = IDLE;
        endcase
    end

    always_comb tx_dv = state == LAUNCH;
endmodule

// File: tb/tb_uart_echo_fifo.sv
// tb_uart_echo_fifo: directed bench for uart_echo_fifo (default depth and a 4-deep instance).
module tb_uart_echo_fifo;
    logic ICE_CLK = 1'b0;
    logic RST_N = 1'b0;
    logic rx_dv = 1'b0, tx_done = 1'b1, tx_dv, full, empty, overflow;
    logic [7:0] rx_byte = 8'h00, tx_byte;
    logic [9:0] count;
    logic rx_dv_s = 1'b0, tx_done_s = 1'b1, tx_dv_s, full_s, empty_s, overflow_s;
    logic [7:0] rx_byte_s = 8'h00, tx_byte_s;
    logic [2:0] count_s;
    int passed = 0, total = 0;

    always #5 ICE_CLK = ~ICE_CLK;

    uart_echo_fifo dut (
        .ICE_CLK(ICE_CLK), .RST_N(RST_N), .rx_dv(rx_dv), .rx_byte(rx_byte), .tx_done(tx_done),
        .tx_dv(tx_dv), .tx_byte(tx_byte), .count(count), .full(full), .empty(empty), .overflow(overflow)
    );

    uart_echo_fifo #(.ADDR_W(2)) dut_s (
        .ICE_CLK(ICE_CLK), .RST_N(RST_N), .rx_dv(rx_dv_s), .rx_byte(rx_byte_s), .tx_done(tx_done_s),
        .tx_dv(tx_dv_s), .tx_byte(tx_byte_s), .count(count_s), .full(full_s), .empty(empty_s), .overflow(overflow_s)
    );

    task automatic tick();
        @(negedge ICE_CLK);
    endtask

    function automatic bit tdv(input bit s);
        return s ? tx_dv_s : tx_dv;
    endfunction

    task automatic set_done(input bit s, input logic v);
        if (s) tx_done_s = v; else tx_done = v;
    endtask

    task automatic send(input bit s, input logic [7:0] b);
        if (s) begin rx_dv_s = 1'b1; rx_byte_s = b; end else begin rx_dv = 1'b1; rx_byte = b; end
        tick();
        if (s) rx_dv_s = 1'b0; else rx_dv = 1'b0;
    endtask

    // transmitter model: waits (bounded) for a launch, then goes busy for 3 cycles
    task automatic xmit(input bit s, output bit got, output logic [7:0] b, output int extra);
        got = 1'b0; b = 8'h00; extra = 0;
        for (int i = 0; i < 30 && !got; i++)
            if (tdv(s)) begin got = 1'b1; b = s ? tx_byte_s : tx_byte; end
            else tick();
        if (got) begin
            set_done(s, 1'b0);
            for (int i = 0; i < 3; i++) begin tick(); extra += int'(tdv(s)); end
            set_done(s, 1'b1);
            tick();
        end
    endtask

    task automatic test_reset();
        RST_N = 1'b0;
        tick(); tick();
        total++; if (tx_dv !== 1'b0) $display("FAIL reset_tx_dv got %b want 0", tx_dv); else passed++;
        total++; if (tx_byte !== 8'h00) $display("FAIL reset_tx_byte got %h want 00", tx_byte); else passed++;
        total++; if (count !== 10'd0) $display("FAIL reset_count got %0d want 0", count); else passed++;
        total++; if ({empty, full, overflow} !== 3'b100) $display("FAIL reset_flags got %b want 100", {empty, full, overflow}); else passed++;
        total++; if ({empty_s, full_s, overflow_s, count_s} !== 6'b100000) $display("FAIL reset_small got %b want 100000", {empty_s, full_s, overflow_s, count_s}); else passed++;
        RST_N = 1'b1;
        tick();
    endtask

    task automatic test_first_byte();
        tx_done = 1'b1;
        send(0, 8'h41);
        total++; if (count !== 10'd1) $display("FAIL first_count got %0d want 1", count); else passed++;
        total++; if (tx_dv !== 1'b0) $display("FAIL first_early1 got %b want 0", tx_dv); else passed++;
        tick();
        total++; if (tx_dv !== 1'b0) $display("FAIL first_early2 got %b want 0", tx_dv); else passed++;
        tick();
        total++; if (tx_dv !== 1'b1) $display("FAIL first_latency got %b want 1", tx_dv); else passed++;
        total++; if (tx_byte !== 8'h41) $display("FAIL first_byte got %h want 41", tx_byte); else passed++;
        tx_done = 1'b0;
        tick();
        total++; if ({tx_dv, empty, count} !== {2'b01, 10'd0}) $display("FAIL first_after got %b want 01_0", {tx_dv, empty, count}); else passed++;
        tick();
        tx_done = 1'b1;
        tick(); tick();
    endtask

    task automatic test_burst();
        bit got;
        logic [7:0] b;
        int extra, seen;
        seen = 0;
        tx_done = 1'b0;
        for (int i = 1; i <= 5; i++) begin send(0, 8'(i)); seen += int'(tx_dv); end
        for (int i = 0; i < 4; i++) begin tick(); seen += int'(tx_dv); end
        total++; if (count !== 10'd5) $display("FAIL burst_count got %0d want 5", count); else passed++;
        total++; if (seen != 0) $display("FAIL burst_no_launch got %0d want 0", seen); else passed++;
        tx_done = 1'b1;
        for (int i = 1; i <= 5; i++) begin
            xmit(0, got, b, extra);
            total++; if (!got || b !== 8'(i)) $display("FAIL burst_order got %b/%h want 1/%h", got, b, 8'(i)); else passed++;
            total++; if (extra != 0) $display("FAIL burst_single_pulse got %0d want 0", extra); else passed++;
        end
        total++; if (empty !== 1'b1) $display("FAIL burst_empty got %b want 1", empty); else passed++;
    endtask

    task automatic test_overflow();
        bit got;
        logic [7:0] b;
        int extra, seen;
        tx_done_s = 1'b0;
        for (int i = 0; i < 4; i++) send(1, 8'hA1 + 8'(i));
        total++; if ({full_s, overflow_s, count_s} !== 5'b10100) $display("FAIL ovf_full got %b want 10100", {full_s, overflow_s, count_s}); else passed++;
        send(1, 8'hA5);
        total++; if ({full_s, overflow_s, count_s} !== 5'b11100) $display("FAIL ovf_drop got %b want 11100", {full_s, overflow_s, count_s}); else passed++;
        tx_done_s = 1'b1;
        for (int i = 0; i < 4; i++) begin
            xmit(1, got, b, extra);
            total++; if (!got || b !== 8'hA1 + 8'(i)) $display("FAIL ovf_drain got %b/%h want 1/%h", got, b, 8'hA1 + 8'(i)); else passed++;
        end
        seen = 0;
        for (int i = 0; i < 10; i++) begin tick(); seen += int'(tx_dv_s); end
        total++; if (seen != 0) $display("FAIL ovf_no_fifth got %0d want 0", seen); else passed++;
        total++; if ({empty_s, overflow_s} !== 2'b11) $display("FAIL ovf_sticky got %b want 11", {empty_s, overflow_s}); else passed++;
        RST_N = 1'b0;
        tick();
        RST_N = 1'b1;
        tick();
        total++; if (overflow_s !== 1'b0) $display("FAIL ovf_cleared got %b want 0", overflow_s); else passed++;
    endtask

    task automatic test_reset_mid();
        bit got;
        logic [7:0] b;
        int extra, seen;
        tx_done = 1'b0;
        for (int i = 0; i < 4; i++) send(0, 8'h51 + 8'(i));
        tx_done = 1'b1;
        got = 1'b0;
        for (int i = 0; i < 20 && !got; i++) if (tx_dv) got = 1'b1; else tick();
        total++; if (!got || tx_byte !== 8'h51) $display("FAIL mid_launch got %b/%h want 1/51", got, tx_byte); else passed++;
        tick();
        total++; if (count !== 10'd3) $display("FAIL mid_count got %0d want 3", count); else passed++;
        tx_done = 1'b0;
        RST_N = 1'b0;
        #1;
        total++; if ({tx_dv, empty, count} !== {2'b01, 10'd0}) $display("FAIL mid_async got %b want 01_0", {tx_dv, empty, count}); else passed++;
        total++; if (tx_byte !== 8'h00) $display("FAIL mid_tx_byte got %h want 00", tx_byte); else passed++;
        tick();
        RST_N = 1'b1;
        tick();
        send(0, 8'h66);
        seen = 0;
        for (int i = 0; i < 8; i++) begin tick(); seen += int'(tx_dv); end
        total++; if (seen != 0 || count !== 10'd1) $display("FAIL mid_hold got %0d/%0d want 0/1", seen, count); else passed++;
        tx_done = 1'b1;
        xmit(0, got, b, extra);
        total++; if (!got || b !== 8'h66) $display("FAIL mid_resume got %b/%h want 1/66", got, b); else passed++;
    endtask

    task automatic test_line_mode();
        bit got;
        logic [7:0] b;
        logic [7:0] exp_b [3] = '{8'h41, 8'h42, 8'h0D};
        int extra, seen;
        tx_done = 1'b1;
        send(0, 8'h41);
        send(0, 8'h42);
        seen = 0;
        for (int i = 0; i < 8; i++) begin tick(); seen += int'(tx_dv); end
        total++; if (seen != 0 || count !== 10'd2) $display("FAIL line_hold got %0d/%0d want 0/2", seen, count); else passed++;
        send(0, 8'h0D);
        for (int i = 0; i < 3; i++) begin
            xmit(0, got, b, extra);
            total++; if (!got || b !== exp_b[i]) $display("FAIL line_release got %b/%h want 1/%h", got, b, exp_b[i]); else passed++;
        end
        send(0, 8'h43);
        seen = 0;
        for (int i = 0; i < 8; i++) begin tick(); seen += int'(tx_dv); end
        total++; if (seen != 0 || count !== 10'd1) $display("FAIL line_counter_zero got %0d/%0d want 0/1", seen, count); else passed++;
        tx_done_s = 1'b1;
        for (int i = 0; i < 4; i++) send(1, 8'h31 + 8'(i));
        xmit(1, got, b, extra);
        total++; if (!got || b !== 8'h31) $display("FAIL line_full_release got %b/%h want 1/31", got, b); else passed++;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog time limit reached");
        $fatal(1);
    end

    initial begin
        test_reset();
`ifdef UART_ECHO_LINE_EN
        test_line_mode();
`else
        test_first_byte();
        test_burst();
        test_overflow();
        test_reset_mid();
`endif
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
